seg7_scan_driver: RTL and testbench

- Time-multiplexed seven-segment display driver. Sits directly downstream of the processor core on the FPGA board.
- Consumes packed hex nibbles (result registers, cycle count) and produces active-low anode and cathode drives for an N-digit common-anode display.
- Generates its own scan rate from the system clock, inserts a ghost-suppression blanking gap before each digit, and snapshots input data once per frame so digits never tear mid-frame.

---
 rtl/seg7_pkg.sv | 39 +++
 rtl/seg7_scan_driver_if.sv | 23 ++
 rtl/seg7_tick_gen.sv | 28 ++
 rtl/seg7_scan_driver.sv | 134 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared types, constants and the hex-to-cathode decoder for the seven-segment scan driver.
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Active-low {A,B,C,D,E,F,G}, bit 6 = A.
    function automatic logic [6:0] hex2seg(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Data inputs from the core and display drives of the seven-segment scan driver.
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 8
);
    logic [4*NUM_DIGITS-1:0] digits_i;
    logic [NUM_DIGITS-1:0]   digit_en_i;
    logic [NUM_DIGITS-1:0]   dp_i;
    logic                    freeze_i;
    logic [NUM_DIGITS-1:0]   an_o;
    logic [6:0]              seg_o;
    logic                    dp_o;
    logic                    frame_start_o;

    modport master (
        output digits_i, digit_en_i, dp_i, freeze_i,
        input  an_o, seg_o, dp_o, frame_start_o
    );

    modport slave (
        input  digits_i, digit_en_i, dp_i, freeze_i,
        output an_o, seg_o, dp_o, frame_start_o
    );
endinterface

// File: rtl/seg7_tick_gen.sv
// Slot prescaler: presc runs 0..DIV-1 and slot_wrap flags the last cycle of each slot.
module seg7_tick_gen
    import seg7_pkg::*;
#(
    parameter int DIV     = 10,
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    output logic [PRESC_W-1:0] presc,
    output logic               slot_wrap
);

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DIV - 1);

    assign slot_wrap = (presc == PRESC_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc <= '0;
        end else if (slot_wrap) begin
            presc <= '0;
        end else begin
            presc <= presc + PRESC_W'(1);
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with per-slot blanking and per-frame snapshot.
//
//   state    | meaning
//   ST_BLANK | start of slot, all anodes off to suppress ghosting
//   ST_SHOW  | current digit driven from the frame snapshot
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int SCAN_HZ      = 800,
    parameter int NUM_DIGITS   = 8,
    parameter int BLANK_CYCLES = 1000
) (
    input logic               clk,
    input logic               reset,
    seg7_scan_driver_if.slave bus
);

    localparam int DIV     = CLK_HZ / SCAN_HZ;
    localparam int PRESC_W = idx_width(DIV);
    localparam int IDX_W   = idx_width(NUM_DIGITS);

    localparam logic [PRESC_W-1:0] BLANK_LAST = PRESC_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    generate
        if (BLANK_CYCLES < 1 || BLANK_CYCLES >= DIV) begin : g_bad_blank
            $error("seg7_scan_driver: BLANK_CYCLES must satisfy 1 <= BLANK_CYCLES < CLK_HZ/SCAN_HZ");
        end
    endgenerate

    logic [PRESC_W-1:0]      presc;
    logic                    slot_wrap;
    logic [IDX_W-1:0]        idx, idx_nxt;
    scan_state_t             state, state_nxt;
    logic                    frame_start;
    logic                    snap_load;

    logic [4*NUM_DIGITS-1:0] snap_digits, snap_digits_nxt;
    logic [NUM_DIGITS-1:0]   snap_en, snap_en_nxt;
    logic [NUM_DIGITS-1:0]   snap_dp, snap_dp_nxt;

    logic [NUM_DIGITS-1:0]   an_q, an_nxt;
    logic [6:0]              seg_q, seg_nxt;
    logic                    dp_q, dp_nxt;

    seg7_tick_gen #(
        .DIV     (DIV),
        .PRESC_W (PRESC_W)
    ) u_tick_gen (
        .clk       (clk),
        .reset     (reset),
        .presc     (presc),
        .slot_wrap (slot_wrap)
    );

    // Gated by reset so the pulse is visible in the very first cycle after release but never during reset.
    assign frame_start = reset && (presc == '0) && (idx == '0);
    assign snap_load   = frame_start && !bus.freeze_i;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_BLANK;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        if (slot_wrap) begin
            state_nxt = ST_BLANK;
            idx_nxt   = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end else if (presc == BLANK_LAST) begin
            state_nxt = ST_SHOW;
        end
    end

    always_comb begin
        snap_digits_nxt = snap_digits;
        snap_en_nxt     = snap_en;
        snap_dp_nxt     = snap_dp;
        if (snap_load) begin
            snap_digits_nxt = bus.digits_i;
            snap_en_nxt     = bus.digit_en_i;
            snap_dp_nxt     = bus.dp_i;
        end
    end

    // Outputs are decoded from next-cycle values so they switch on the same edge as the state.
    always_comb begin
        an_nxt  = '1;
        seg_nxt = SEG_OFF;
        dp_nxt  = 1'b1;
        if (state_nxt == ST_SHOW) begin
            an_nxt[idx_nxt] = ~snap_en_nxt[idx_nxt];
            seg_nxt         = hex2seg(snap_digits_nxt[{idx_nxt, 2'b00} +: 4]);
            dp_nxt          = ~snap_dp_nxt[idx_nxt];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            snap_digits <= '0;
            snap_en     <= '0;
            snap_dp     <= '0;
        end else begin
            snap_digits <= snap_digits_nxt;
            snap_en     <= snap_en_nxt;
            snap_dp     <= snap_dp_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            an_q  <= '1;
            seg_q <= SEG_OFF;
            dp_q  <= 1'b1;
        end else begin
            an_q  <= an_nxt;
            seg_q <= seg_nxt;
            dp_q  <= dp_nxt;
        end
    end

    assign bus.an_o          = an_q;
    assign bus.seg_o         = seg_q;
    assign bus.dp_o          = dp_q;
    assign bus.frame_start_o = frame_start;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: cycle-time reference model plus directed and random stimulus.
module tb_seg7_scan_driver;

    localparam int ND    = 4;
    localparam int DIVV  = 10;
    localparam int BLANK = 2;
    localparam int FRAME = DIVV * ND;

    logic clk;
    logic reset;

    seg7_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

    seg7_scan_driver #(
        .CLK_HZ       (1000),
        .SCAN_HZ      (100),
        .NUM_DIGITS   (ND),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [6:0] seg_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    // Model: t counts cycles since reset release; slot, digit and phase follow by division.
    int              t;
    logic [4*ND-1:0] m_dig;
    logic [ND-1:0]   m_en;
    logic [ND-1:0]   m_dp;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0d actual=%0h required=%0h", name, t, act, exp);
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            t     = 0;
            m_dig = '0;
            m_en  = '0;
            m_dp  = '0;
        end else begin
            if (t % FRAME == 0 && !bus.freeze_i) begin
                m_dig = bus.digits_i;
                m_en  = bus.digit_en_i;
                m_dp  = bus.dp_i;
            end
            t++;
        end
    end

    always @(negedge clk) begin
        int         p, k;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp, e_fs;
        e_an  = '1;
        e_seg = 7'h7F;
        e_dp  = 1'b1;
        e_fs  = 1'b0;
        if (reset) begin
            p    = t % DIVV;
            k    = (t / DIVV) % ND;
            e_fs = (t % FRAME == 0);
            if (p >= BLANK) begin
                if (m_en[k]) e_an[k] = 1'b0;
                e_seg = seg_tab[m_dig[4*k +: 4]];
                e_dp  = ~m_dp[k];
            end
        end
        chk("an_o", 32'(bus.an_o), 32'(e_an));
        chk("seg_o", 32'(bus.seg_o), 32'(e_seg));
        chk("dp_o", 32'(bus.dp_o), 32'(e_dp));
        chk("frame_start_o", 32'(bus.frame_start_o), 32'(e_fs));
    end

    task automatic at_t(input int target);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (t != target && n < 3000);
        if (t != target) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_t actual=%0d required=%0d", t, target);
        end
    endtask

    initial begin
        int tgt;
        reset          = 1'b0;
        bus.digits_i   = 16'h4321;
        bus.digit_en_i = 4'hF;
        bus.dp_i       = 4'h0;
        bus.freeze_i   = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;

        at_t(0);  chk("lit_fs0", 32'(bus.frame_start_o), 32'd1); chk("lit_an0", 32'(bus.an_o), 32'hF);
        at_t(1);  chk("lit_fs1", 32'(bus.frame_start_o), 32'd0); chk("lit_an1", 32'(bus.an_o), 32'hF);
        at_t(2);  chk("lit_an2", 32'(bus.an_o), 32'hE); chk("lit_seg2", 32'(bus.seg_o), 32'b1001111);
        at_t(12); chk("lit_an12", 32'(bus.an_o), 32'hD); chk("lit_seg12", 32'(bus.seg_o), 32'b0010010);
        at_t(22); chk("lit_an22", 32'(bus.an_o), 32'hB); chk("lit_seg22", 32'(bus.seg_o), 32'b0000110);
        at_t(32); chk("lit_an32", 32'(bus.an_o), 32'h7); chk("lit_seg32", 32'(bus.seg_o), 32'b1001100);
        at_t(40); chk("lit_fs40", 32'(bus.frame_start_o), 32'd1);

        at_t(41); bus.digit_en_i = 4'b1010;
        at_t(82); chk("lit_dis_an82", 32'(bus.an_o), 32'hF);
        at_t(92); chk("lit_en_an92", 32'(bus.an_o), 32'hD);

        at_t(125); bus.digits_i = 16'hFEDC; bus.digit_en_i = 4'hF;
        at_t(132); chk("lit_old_seg132", 32'(bus.seg_o), 32'b0010010);
        at_t(162); chk("lit_an162", 32'(bus.an_o), 32'hE); chk("lit_C", 32'(bus.seg_o), 32'b0110001);
        at_t(172); chk("lit_d", 32'(bus.seg_o), 32'b1000010);
        at_t(182); chk("lit_E", 32'(bus.seg_o), 32'b0110000);
        at_t(192); chk("lit_F", 32'(bus.seg_o), 32'b0111000);

        at_t(195); bus.freeze_i = 1'b1;
        at_t(205); bus.digits_i = 16'h9876;
        at_t(242); chk("lit_frz242", 32'(bus.seg_o), 32'b0110001);
        at_t(282); chk("lit_frz282", 32'(bus.seg_o), 32'b0110001);
        at_t(290); bus.freeze_i = 1'b0;
        at_t(322); chk("lit_new6", 32'(bus.seg_o), 32'b0100000);
        at_t(332); chk("lit_new7", 32'(bus.seg_o), 32'b0001111);

        for (int c = 0; c < 1200; c++) begin
            @(posedge clk);
            #1;
            if ($urandom_range(7) == 0) bus.digits_i = 16'($urandom);
            if ($urandom_range(7) == 0) bus.digit_en_i = 4'($urandom);
            if ($urandom_range(7) == 0) bus.dp_i = 4'($urandom);
            if ($urandom_range(31) == 0) bus.freeze_i = ~bus.freeze_i;
        end

        bus.digits_i   = 16'h4321;
        bus.digit_en_i = 4'hF;
        bus.dp_i       = 4'b0101;
        bus.freeze_i   = 1'b0;
        tgt = ((t / FRAME) + 1) * FRAME + 25;
        at_t(tgt);
        chk("lit_pre_rst_an", 32'(bus.an_o) & 32'h4, 32'h0);
        #2 reset = 1'b0;
        #1;
        chk("lit_rst_an", 32'(bus.an_o), 32'hF);
        chk("lit_rst_seg", 32'(bus.seg_o), 32'h7F);
        chk("lit_rst_dp", 32'(bus.dp_o), 32'd1);
        chk("lit_rst_fs", 32'(bus.frame_start_o), 32'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        at_t(0); chk("lit_rel_fs", 32'(bus.frame_start_o), 32'd1); chk("lit_rel_an0", 32'(bus.an_o), 32'hF);
        at_t(1); chk("lit_rel_an1", 32'(bus.an_o), 32'hF);
        at_t(2); chk("lit_rel_an2", 32'(bus.an_o), 32'hE); chk("lit_rel_seg2", 32'(bus.seg_o), 32'b1001111);
        chk("lit_rel_dp2", 32'(bus.dp_o), 32'd0);
        repeat (80) @(posedge clk);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
